clk_gate_ctrl: RTL
==================

# clk_gate_ctrl

Activity-based enable controller for the latch-based clock gate cell: it produces the `CLK_EN` that the gate cell latches, so a gated sub-block (e.g. ALU) is clocked only while it has work. It provides the wake-up/ready handshake that requesters must observe before issuing work into the gated domain. It also keeps a saturating count of gated-off cycles for power monitoring. It sits in the system top, always-on `CLK` domain, beside the gate cell it drives.

## Interface
- `IDLE_CYCLES`, default 4: consecutive idle cycles in ON before entering SLEEP. Legal range 1..255.
- `WAKE_CYCLES`, default 2: cycles with `CLK_EN` high before `CLK_READY` asserts. Legal range 1..15.
- `CNT_W`, default 16: width of `GATED_CNT`.
- `CLK` in 1: always-on clock. All logic is on its rising edge.
- `RST` in 1: reset, asynchronous, active-low.
- `WAKE_REQ` in 1: level request for the gated clock. Requester holds it until it has received `CLK_READY` and issued its work.
- `BUSY` in 1: gated block still processing. Synchronous to `CLK`.
- `FORCE_ON` in 1: test/debug override. Keeps the clock enabled.
- `CLK_EN` out 1: enable to the gate cell. Driven directly from a flop, with no logic after the register.
- `CLK_READY` out 1: gated clock is stable and work may be issued.
- `GATED_CNT` out `CNT_W`: number of cycles spent in OFF. Saturates at all-ones.
- `STATE` out 2: current FSM state, for debug.

## Operation
- Idle sample: `WAKE_REQ`=0, `BUSY`=0 and `FORCE_ON`=0 at the edge. Any other combination is "active".
- States and their outputs:
  - OFF: `CLK_EN`=0, `CLK_READY`=0.
  - WAKE: `CLK_EN`=1, `CLK_READY`=0.
  - ON: `CLK_EN`=1, `CLK_READY`=1.
  - SLEEP: `CLK_EN`=1, `CLK_READY`=0.
- OFF to WAKE: `WAKE_REQ` or `FORCE_ON` is sampled high. `BUSY` alone does not wake the block, since it cannot rise while the clock is off.
- WAKE: the wake counter loads 0 on entry and increments each cycle. The block moves to ON on the edge where the counter equals `WAKE_CYCLES`-1. Inputs are ignored while in WAKE.
- ON: the idle counter clears on every active sample and increments on every idle sample. The block moves to SLEEP on the idle sample at which the counter equals `IDLE_CYCLES`-1.
- SLEEP: this is one cycle of `CLK_READY` low with the clock still running, so requesters see the drop before the clock stops.
  - An active sample returns the block to ON, with no wake delay and the idle counter cleared.
  - An idle sample moves the block to OFF.
- `GATED_CNT` increments on every edge that ends in OFF and holds when all-ones.
- All outputs are registered. `STATE`, `CLK_EN` and `CLK_READY` are decoded from the state register.
- Reset values: state OFF, `CLK_EN`=0, `CLK_READY`=0, `GATED_CNT`=0, both internal counters 0, `STATE`=2'b00.
- Reset asserted mid-operation forces OFF immediately, with `CLK_EN` dropping asynchronously. The gate cell's latch absorbs this without a glitch while `CLK` is low.

## Timing
- Wake latency: with `WAKE_REQ` sampled high at edge k in OFF:
  - `CLK_EN` is high after edge k.
  - `CLK_READY` is high after edge k+`WAKE_CYCLES`.
- Gate latency: the last active sample at edge j in ON gives:
  - `CLK_READY` low after edge j+`IDLE_CYCLES`.
  - `CLK_EN` low after edge j+`IDLE_CYCLES`+1.
- `CLK_EN` changes only just after a rising edge, so the gate cell's low-phase latch captures it glitch-free.
- `WAKE_REQ` at the same edge as the SLEEP-to-OFF decision counts as active, so the block stays in ON. No request is lost.
- `FORCE_ON` high pins the block in WAKE/ON indefinitely. `GATED_CNT` holds.

## Structure
- Shared package holds:
  - state encodings: OFF=2'b00, WAKE=2'b01, ON=2'b10, SLEEP=2'b11;
  - the `CNT_W` default.
- One sub-module is natural: `idle_timer`, a loadable up-counter with a terminal-compare output, instantiated twice (wake counter and idle counter).
- The top level instantiates `clk_gate_ctrl` plus the gate cell. `CLK_EN` is wired to the gate cell's enable input only.

## Test plan
- Reset then 10 idle cycles: `CLK_EN`=0, `CLK_READY`=0, `STATE`=00, `GATED_CNT`=10.
- `WAKE_REQ` pulse at edge 0 (`WAKE_CYCLES`=2): `CLK_EN`=1 after edge 0, `CLK_READY`=1 after edge 2, `STATE`=10.
- Defaults, block in ON, `BUSY` falls at edge 20: `CLK_READY`=0 after edge 24, `CLK_EN`=0 after edge 25, `GATED_CNT` resumes incrementing.
- `WAKE_REQ` asserted during the SLEEP cycle: returns to ON next edge, `CLK_READY`=1, `CLK_EN` never drops.
- `FORCE_ON` held for 100 cycles with other inputs idle: `CLK_EN`=1 throughout, `GATED_CNT` unchanged.
- `RST` low while in ON between edges: `CLK_EN` and `CLK_READY` go 0 immediately. After release, the block stays OFF until `WAKE_REQ`.

Source files
------------

// File: rtl/clk_gate_ctrl_pkg.sv
// Shared definitions for the activity-based clock-gate enable controller.
package clk_gate_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_WAKE  = 2'b01,
        ST_ON    = 2'b10,
        ST_SLEEP = 2'b11
    } gate_state_e;

    localparam int CNT_W_DEFAULT = 16;
    // Both internal timers are sized for the widest terminal count (IDLE_CYCLES up to 255).
    localparam int TIMER_W = 8;

endpackage

// File: rtl/clk_gate_ctrl_idle_timer.sv
// Clearable up-counter with a terminal-compare flag; used as wake and idle timer.
module idle_timer
    import clk_gate_ctrl_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] term_i,
    output logic         hit_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Enable controller for a latch-based clock gate: wake/ready handshake, idle
// timeout with a one-cycle ready-drop warning, and a saturating gated-cycle count.
module clk_gate_ctrl
    import clk_gate_ctrl_pkg::*;
#(
    parameter int IDLE_CYCLES = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = CNT_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             WAKE_REQ,
    input  logic             BUSY,
    input  logic             FORCE_ON,
    output logic             CLK_EN,
    output logic             CLK_READY,
    output logic [CNT_W-1:0] GATED_CNT,
    output logic [1:0]       STATE
);

    localparam logic [TIMER_W-1:0] IDLE_TERM = TIMER_W'(IDLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] WAKE_TERM = TIMER_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

    gate_state_e      state_q, state_d;
    logic             clk_en_q, clk_ready_q;
    logic [CNT_W-1:0] gated_cnt_q, gated_cnt_d;

    logic idle_s;
    logic wake_hit, idle_hit;
    logic wake_clr, wake_inc;
    logic idle_clr, idle_inc;

    assign idle_s = !WAKE_REQ && !BUSY && !FORCE_ON;

    // Wake timer sits at zero outside WAKE, so it starts from 0 on every entry.
    assign wake_clr = (state_q != ST_WAKE);
    assign wake_inc = (state_q == ST_WAKE);
    assign idle_clr = (state_q != ST_ON) || !idle_s;
    assign idle_inc = (state_q == ST_ON) && idle_s && !idle_hit;

    idle_timer #(.W(TIMER_W)) u_wake_timer (
        .clk_i  (CLK),
        .rst_ni (RST),
        .clr_i  (wake_clr),
        .inc_i  (wake_inc),
        .term_i (WAKE_TERM),
        .hit_o  (wake_hit)
    );

    idle_timer #(.W(TIMER_W)) u_idle_timer (
        .clk_i  (CLK),
        .rst_ni (RST),
        .clr_i  (idle_clr),
        .inc_i  (idle_inc),
        .term_i (IDLE_TERM),
        .hit_o  (idle_hit)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:   if (WAKE_REQ || FORCE_ON) state_d = ST_WAKE;
            ST_WAKE:  if (wake_hit) state_d = ST_ON;
            ST_ON:    if (idle_s && idle_hit) state_d = ST_SLEEP;
            ST_SLEEP: state_d = idle_s ? ST_OFF : ST_ON;
            default:  state_d = ST_OFF;
        endcase
    end

    always_comb begin
        gated_cnt_d = gated_cnt_q;
        if ((state_d == ST_OFF) && (gated_cnt_q != '1)) begin
            gated_cnt_d = gated_cnt_q + CNT_ONE;
        end
    end

    // Enable and ready are decoded ahead of the register so the gate cell sees a bare flop.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_OFF;
            clk_en_q    <= 1'b0;
            clk_ready_q <= 1'b0;
            gated_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            clk_en_q    <= (state_d != ST_OFF);
            clk_ready_q <= (state_d == ST_ON);
            gated_cnt_q <= gated_cnt_d;
        end
    end

    assign CLK_EN    = clk_en_q;
    assign CLK_READY = clk_ready_q;
    assign GATED_CNT = gated_cnt_q;
    assign STATE     = state_q;

endmodule
